// File: rtl/audio_sigma_delta_player.sv
// Buffers unsigned audio samples and plays one per sample-rate tick as a 1-bit first-order delta-sigma stream.
// Latency: a pop reaches the modulator input 1 cycle later, and dac_out reflects it 1 cycle after that.
// Backpressure: s_ready is low while the FIFO holds FIFO_DEPTH samples; it depends only on registered state.

module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_vld,
    output logic [W-1:0]  head_dat,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok  = push_vld && (level != LW'(DEPTH));
    assign pop_ok   = pop_vld && (level != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

module audio_sigma_delta_player #(
    parameter int CLK_HZ     = 54000000,
    parameter int SAMPLE_HZ  = 8000,
    parameter int SAMPLE_W   = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                dac_out,
    output logic                sample_tick,
    output logic                playing,
    output logic                underrun,
    output logic [7:0]          underrun_cnt,
    output logic [LW-1:0]       fifo_level
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       tick_cnt;
    logic [SAMPLE_W-1:0] cur_sample;
    logic [SAMPLE_W-1:0] head_dat;
    logic [SAMPLE_W:0]   acc;
    logic [SAMPLE_W:0]   acc_next;
    logic                push;
    logic                pop;
    logic                tick;

    assign s_ready     = (fifo_level != LW'(FIFO_DEPTH));
    assign push        = s_valid && s_ready;
    assign playing     = (state == PLAY);
    assign tick        = playing && (tick_cnt == CW'(DIV - 1));
    assign sample_tick = tick;
    assign pop         = tick && (fifo_level != '0);
    assign underrun    = tick && (fifo_level == '0);

    // The carry out of the low SAMPLE_W bits is the output bit; it is held in acc's MSB.
    assign acc_next = {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, cur_sample};
    assign dac_out  = acc[SAMPLE_W];

    sync_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push),
        .push_dat (s_data),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .level    (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            cur_sample   <= MIDSCALE;
            underrun_cnt <= '0;
            acc          <= '0;
        end else begin
            acc <= acc_next;
            if (underrun && (underrun_cnt != 8'hFF)) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
            case (state)
                IDLE: begin
                    tick_cnt   <= '0;
                    cur_sample <= MIDSCALE;
                    if (enable) begin
                        state <= PRIME;
                    end
                end
                PRIME: begin
                    tick_cnt   <= '0;
                    cur_sample <= MIDSCALE;
                    if (!enable) begin
                        state <= IDLE;
                    end else if (fifo_level >= LW'(FIFO_DEPTH / 2)) begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (pop) begin
                        cur_sample <= head_dat;
                    end else if (underrun) begin
                        cur_sample <= MIDSCALE;
                    end
                    // Leaving PLAY still lets this cycle's tick pop, but the output returns to midscale.
                    if (!enable) begin
                        state      <= IDLE;
                        tick_cnt   <= '0;
                        cur_sample <= MIDSCALE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    tick_cnt   <= '0;
                    cur_sample <= MIDSCALE;
                end
            endcase
        end
    end

endmodule

// File: doc/audio_sigma_delta_player.md
Name: audio_sigma_delta_player

Overview:
- Downstream consumer of the 54 MHz PLL output clock (27 MHz × 2).
- Accepts unsigned audio samples from the stream source over a valid/ready handshake and buffers them in a small FIFO.
- Releases one sample per sample-rate tick, derived by integer division of the system clock.
- Converts the current sample to a 1-bit first-order delta-sigma bitstream that drives the board's audio pin through an external RC filter.

Parameters:
- CLK_HZ, 54000000, frequency of clk in Hz.
- SAMPLE_HZ, 8000, audio sample rate in Hz. DIV = CLK_HZ/SAMPLE_HZ (integer, must be ≥ 2).
- SAMPLE_W, 8, sample width in bits, unsigned, midscale = 2^(SAMPLE_W-1).
- FIFO_DEPTH, 16, FIFO entries. Must be a power of 2 and ≥ 4. LW = log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock from the PLL clkout, single clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  playback request level.
- s_data  in  SAMPLE_W  incoming sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept a sample.
- dac_out  out  1  delta-sigma bitstream.
- sample_tick  out  1  one-cycle pulse at each sample-rate tick (PLAY only).
- playing  out  1  high in state PLAY.
- underrun  out  1  one-cycle pulse when a tick finds the FIFO empty.
- underrun_cnt  out  8  saturating count of underruns since reset.
- fifo_level  out  LW  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Everything is clocked on the rising edge of clk. rst is synchronous, active-high and has priority over all other inputs.
- Reset values:
  - Outputs: s_ready=1, dac_out=0, sample_tick=0, playing=0, underrun=0, underrun_cnt=0, fifo_level=0.
  - Internal: FIFO pointers=0, tick counter=0, cur_sample=midscale, accumulator=0, state=IDLE.
- Handshake and FIFO:
  - s_ready = (fifo_level != FIFO_DEPTH). This is registered-state based and has no combinational path from s_valid.
  - Push occurs when s_valid && s_ready. Data appears in fifo_level on the next cycle.
  - Push while full cannot occur because s_ready=0; s_data is ignored.
  - Pop occurs only on a tick in PLAY with level > 0.
  - Simultaneous push and pop: both occur and level is unchanged. This includes the level==FIFO_DEPTH case, where no push is possible, so only the pop occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: cur_sample=midscale and the tick counter is held at 0. Pushes are still accepted. Goes to PRIME when enable=1.
  - PRIME: waits until fifo_level ≥ FIFO_DEPTH/2, then goes to PLAY and clears the tick counter to 0. Goes to IDLE if enable=0.
  - PLAY: the tick counter runs 0..DIV-1. When count==DIV-1, sample_tick=1 for that cycle and the counter wraps to 0.
    - On a tick with level>0: pop the head into cur_sample, visible on the next cycle.
    - On a tick with level==0: cur_sample becomes midscale, underrun pulses, and underrun_cnt increments, saturating at 255. The FSM stays in PLAY; no re-prime.
    - enable=0 gives IDLE on the next cycle: cur_sample becomes midscale, FIFO contents are retained, and any tick in that same cycle is still processed.
- Delta-sigma modulator:
  - Runs every cycle in all states.
  - acc is SAMPLE_W+1 bits: acc_next = {1'b0, acc[SAMPLE_W-1:0]} + cur_sample.
  - dac_out is registered as acc_next[SAMPLE_W].
  - Over 2^SAMPLE_W cycles at constant input x, the count of dac_out ones equals x exactly.
- Latency:
  - Sample accepted to earliest pop: the next tick after PRIME→PLAY.
  - Pop to modulator input: 1 cycle.
  - Modulator input to dac_out effect: 1 cycle.
- Reset mid-operation (any state) returns everything to reset values on the next edge. FIFO contents are discarded.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=1000, SAMPLE_HZ=100 (DIV=10), SAMPLE_W=8, FIFO_DEPTH=16.
- Reset and idle: hold rst 3 cycles, then idle 300 cycles → all outputs at reset values; dac_out emits 128 ones per 256 cycles.
- Priming: enable=1, push 7 samples → playing stays 0. Push the 8th → playing=1 the cycle after level reaches 8; first sample_tick 10 cycles later; head sample lands in cur_sample.
- Fill/full: push 20 samples back-to-back with s_valid=1, enable=0 → s_ready drops after 16 accepts; fifo_level=16; samples 17–20 not accepted.
- Density: play constant 0x40 → exactly 64 ones in any aligned 256-cycle window; 0x00 → all zeros; 0xFF → 255 ones per 256.
- Underrun: prime with 8 samples, no further pushes → 8 ticks pop in push order (checked via density). The 9th tick gives an underrun pulse, underrun_cnt=1 and midscale output. 300 further ticks → underrun_cnt saturates at 255.
- Simultaneous and abort:
  - Push on the exact tick cycle at level=5 → level stays 5.
  - Deassert enable mid-PLAY → playing=0 next cycle; level retained.
  - Assert rst mid-PLAY → level=0 and playing=0 next cycle.
